// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants, bit-period helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    // Frame shape on the wire (the start bit is implicit).
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Bit period in clock cycles, rounded to the nearest integer.
    function automatic int calc_div(input real clk_hz, input real baud);
        return $rtoi(clk_hz / baud + 0.5);
    endfunction

endpackage

// File: rtl/uart_tx_8n1_if.sv
// Byte handshake between the crypter (master) and the UART transmitter (slave).
// Latency: n/a (wires only).
// Backpressure: master may only expect tx_start to be taken while tx_busy is low.
interface uart_tx_8n1_if;
    import uart_pkg::*;

    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_busy;
    logic                 tx_done_tick;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_busy,
        input  tx_done_tick
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_busy,
        output tx_done_tick
    );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..DIV-1 and flags the last cycle of each bit.
// Latency: bit_end is high in the DIV-th cycle after the last clear.
// Backpressure: none; clear restarts the period immediately.
module uart_baud_counter #(
    parameter int DIV = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // Free-running period counter, restarted on clear or wrap.
    always_ff @(posedge clk) begin
        if (rst || clear || bit_end) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign bit_end = (count == LAST);

endmodule

// File: rtl/uart_tx_8n1.sv
// UART transmitter: one byte per accepted tx_start, sent as start + 8 data (LSB first) + stop.
// Latency: start bit on the line from the accepting edge; frame = 10*DIV cycles (11*DIV with UART_TX_PARITY_EN).
// Backpressure: tx_start is ignored while tx_busy is high; no queueing. UART_TX_PARITY_EN adds an even-parity bit.
module uart_tx_8n1
    import uart_pkg::*;
#(
    parameter real CLOCK_FREQUENCY_HZ = 100000000.0,
    parameter real BAUD_RATE          = 115200.0
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_8n1_if.slave  tx_if,
    output logic          tx_stream
);

    localparam int DIV       = calc_div(CLOCK_FREQUENCY_HZ, BAUD_RATE);
    localparam int BIT_CNT_W = $clog2(DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    // A bit period shorter than two cycles cannot be timed by the baud counter.
    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_8n1: bit period DIV=%0d clock cycles, must be >= 2", DIV);
    end

    // The FSM has a single STOP state, so only one stop bit is supported.
    if (STOP_BITS != 1) begin : g_bad_stop
        $error("uart_tx_8n1: only one stop bit is supported");
    end

    uart_state_t           state;
    uart_state_t           state_nxt;
    logic [DATA_BITS-1:0]  shift_q;
    logic [DATA_BITS-1:0]  shift_nxt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt_nxt;
    logic                  bit_end;
    logic                  baud_clear;
    logic                  stream_nxt;
    logic                  busy_nxt;
    logic                  done_nxt;
    logic                  busy_q;
    logic                  done_q;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q;
`endif

    // Keep the period timer parked while idle and restart it on every state change.
    assign baud_clear = (state == ST_IDLE) || (state_nxt != state);

    uart_baud_counter #(
        .DIV (DIV)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (baud_clear),
        .bit_end (bit_end)
    );

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt   <= '0;
            tx_stream <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_q   <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
            tx_stream <= stream_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of the byte, captured with it since the shift register is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (state == ST_IDLE && tx_if.tx_start) begin
            parity_q <= ^tx_if.tx_data;
        end
    end
`endif

    // Next-state: advance one frame slot per bit period, LSB shifted out first.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_q;
        bit_cnt_nxt = bit_cnt;
        case (state)
            ST_IDLE: begin
                if (tx_if.tx_start) begin
                    state_nxt = ST_START;
                    shift_nxt = tx_if.tx_data;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_nxt   = ST_DATA;
                    bit_cnt_nxt = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                        shift_nxt   = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the line changes on the same edge as the state.
    always_comb begin
        stream_nxt = 1'b1;
        busy_nxt   = 1'b1;
        done_nxt   = 1'b0;
        case (state_nxt)
            ST_IDLE: begin
                busy_nxt = 1'b0;
                done_nxt = (state == ST_STOP);
            end
            ST_START: begin
                stream_nxt = 1'b0;
            end
            ST_DATA: begin
                stream_nxt = shift_nxt[0];
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                stream_nxt = parity_q;
            end
`endif
            ST_STOP: begin
                stream_nxt = 1'b1;
            end
            default: begin
                stream_nxt = 1'b1;
                busy_nxt   = 1'b0;
            end
        endcase
    end

    assign tx_if.tx_busy      = busy_q;
    assign tx_if.tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Self-checking bench for uart_tx_8n1 at default parameters (DIV = 868).
// Expected line levels come from a per-slot frame model; random bytes and tx_data noise.
// Follows UART_TX_PARITY_EN when the bundle is built with it.
`timescale 1ns/1ps
module tb_uart_tx_8n1;

    localparam int DIV = 868;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_stream;
    logic [7:0] d_rand;

    int n_chk  = 0;
    int n_pass = 0;

    uart_tx_8n1_if tx_if ();

    uart_tx_8n1 dut (
        .clk       (clk),
        .rst       (rst),
        .tx_if     (tx_if),
        .tx_stream (tx_stream)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line level in each bit slot of a frame: slot 0 = start, 1..8 = data LSB first, then parity/stop.
    function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] d);
        logic [NBITS-1:0] b;
        b    = '1;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b[1 + i] = d[i];
        end
`ifdef UART_TX_PARITY_EN
        b[9] = ^d;
`endif
        return b;
    endfunction

    // Watch n cycles where the transmitter must stay idle.
    task automatic idle_watch(input int n, input string tag);
        int bad_line;
        int bad_busy;
        int bad_done;
        bad_line = 0;
        bad_busy = 0;
        bad_done = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (tx_stream !== 1'b1)          bad_line++;
            if (tx_if.tx_busy !== 1'b0)      bad_busy++;
            if (tx_if.tx_done_tick !== 1'b0) bad_done++;
        end
        chk({tag, "_line_low_cycles"}, bad_line, 0);
        chk({tag, "_busy_cycles"}, bad_busy, 0);
        chk({tag, "_done_cycles"}, bad_done, 0);
    endtask

    // Caller has raised tx_start with byte d; the next edge is edge k.
    // inj_at >= 0 raises tx_start with inj_d for one cycle at offset inj_at
    // (at offset FRAME it is left high so the next frame follows back-to-back).
    task automatic run_frame(input logic [7:0] d, input int inj_at, input logic [7:0] inj_d,
                             input string tag);
        logic [NBITS-1:0] exp_bits;
        int busy_cnt;
        int done_cnt;
        int slot;
        int pos;
        exp_bits = frame_bits(d);
        busy_cnt = 0;
        done_cnt = 0;
        for (int t = 0; t <= FRAME; t++) begin
            tick();
            if (tx_if.tx_busy === 1'b1)      busy_cnt++;
            if (tx_if.tx_done_tick === 1'b1) done_cnt++;
            if (t < FRAME) begin
                slot = t / DIV;
                pos  = t % DIV;
                if (pos == 0 || pos == DIV - 1) begin
                    chk($sformatf("%s_slot%0d_%s", tag, slot, (pos == 0) ? "first" : "last"),
                        tx_stream, exp_bits[slot]);
                end
            end else begin
                chk({tag, "_end_line"}, tx_stream, 1);
                chk({tag, "_end_busy"}, tx_if.tx_busy, 0);
                chk({tag, "_end_done"}, tx_if.tx_done_tick, 1);
            end
            if (t == inj_at) begin
                tx_if.tx_start = 1'b1;
                tx_if.tx_data  = inj_d;
            end else begin
                tx_if.tx_start = 1'b0;
                tx_if.tx_data  = 8'($urandom);
            end
        end
        chk({tag, "_busy_cycles"}, busy_cnt, FRAME);
        chk({tag, "_done_ticks"}, done_cnt, 1);
    endtask

    initial begin
        tx_if.tx_start = 1'b0;
        tx_if.tx_data  = 8'h00;
        rst            = 1'b1;
        repeat (3) tick();
        chk("reset_line", tx_stream, 1);
        chk("reset_busy", tx_if.tx_busy, 0);
        chk("reset_done", tx_if.tx_done_tick, 0);
        rst = 1'b0;
        idle_watch(20000, "idle");

        tx_if.tx_start = 1'b1;
        tx_if.tx_data  = 8'h55;
        run_frame(8'h55, -1, 8'h00, "b55");
        idle_watch(4, "after55");

        tx_if.tx_start = 1'b1;
        tx_if.tx_data  = 8'hA3;
        run_frame(8'hA3, FRAME, 8'h0F, "bA3");
        run_frame(8'h0F, -1, 8'h00, "b0F");
        idle_watch(4, "after_b2b");

        tx_if.tx_start = 1'b1;
        tx_if.tx_data  = 8'h00;
        run_frame(8'h00, 2000, 8'hFF, "reject");
        idle_watch(DIV + 8, "reject_no_second");

        d_rand         = 8'($urandom);
        tx_if.tx_start = 1'b1;
        tx_if.tx_data  = d_rand;
        tick();
        tx_if.tx_start = 1'b0;
        repeat (2999) begin
            tx_if.tx_data = 8'($urandom);
            tick();
        end
        chk("abort_busy_before_rst", tx_if.tx_busy, 1);
        rst = 1'b1;
        tick();
        chk("abort_line", tx_stream, 1);
        chk("abort_busy", tx_if.tx_busy, 0);
        chk("abort_done", tx_if.tx_done_tick, 0);
        rst = 1'b0;
        idle_watch(DIV + 8, "abort_quiet");

        d_rand         = 8'($urandom);
        tx_if.tx_start = 1'b1;
        tx_if.tx_data  = d_rand;
        run_frame(d_rand, -1, 8'h00, "post_abort");
        idle_watch(4, "after_post_abort");

        tx_if.tx_start = 1'b1;
        tx_if.tx_data  = 8'h07;
        run_frame(8'h07, -1, 8'h00, "b07");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_8n1.md
# uart_tx_8n1

Serial transmitter for the board's UART link: accepts one byte per `tx_start` handshake from the crypter and shifts it out on `tx_stream` as an asynchronous 8N1 frame (start bit, 8 data bits LSB first, stop bit). It is the sending end of the `tx_start`/`tx_data`/`tx_busy`/`tx_done_tick` interface the crypter drives. It sits inside the UART block, next to the receiver, on the PLL clock.

## Interface
- `CLOCK_FREQUENCY_HZ`, default 100000000.0 (real): clock frequency of `clk`.
- `BAUD_RATE`, default 115200.0 (real): line rate.
- `clk`  in  1  system clock (PLL output). One clock domain only.
- `rst`  in  1  reset, synchronous and active-high.
- `tx_start`  in  1  request to send `tx_data`; sampled only while idle.
- `tx_data`  in  8  byte to send; sampled in the same cycle as an accepted `tx_start`.
- `tx_stream`  out  1  serial line, registered; idle high.
- `tx_busy`  out  1  frame in progress, registered.
- `tx_done_tick`  out  1  one-cycle pulse when a frame's stop bit completes, registered.

## Operation
- Bit period `DIV` = round(`CLOCK_FREQUENCY_HZ`/`BAUD_RATE`) clock cycles; it is a compile-time integer. At the defaults `DIV` = 868. `DIV` < 2 is a configuration error and is flagged at elaboration.
- FSM states:
  - IDLE -> START on `tx_start`=1. `tx_data` is latched into the shift register.
  - START -> DATA after `DIV` cycles.
  - DATA -> STOP after 8 bits of `DIV` cycles each, sent LSB first.
  - STOP -> IDLE after `DIV` cycles. `tx_done_tick` pulses in the first IDLE cycle.
  - With parity enabled, DATA -> PARITY -> STOP, and PARITY lasts `DIV` cycles.
- Line levels: START drives 0, DATA drives the current shift-register LSB, STOP drives 1, IDLE drives 1.
- Counters:
  - Baud counter: 0..`DIV`-1, width clog2(`DIV`). Reloaded to 0 on every state change.
  - Bit counter: 0..7, 3 bits.
- `tx_start` while `tx_busy`=1 is ignored. No queueing, no error flag.
- `tx_data` changes after acceptance do not affect the frame in progress.
- Reset values: `tx_stream`=1, `tx_busy`=0, `tx_done_tick`=0, FSM=IDLE, counters 0.
- Reset mid-frame: the frame is aborted. The line is high from the cycle after the reset edge. No `tx_done_tick` is issued.

## Timing
- Accepted `tx_start` at edge k: from edge k, `tx_stream`=0 and `tx_busy`=1.
- Start bit spans edges k .. k+`DIV`. Data bit i begins at edge k+(1+i)·`DIV`. Stop bit begins at edge k+9·`DIV`.
- At edge k+10·`DIV` (k+11·`DIV` with parity), `tx_busy` falls and `tx_done_tick` rises for exactly one cycle.
- `tx_start` in the `tx_done_tick` cycle is accepted. The next start bit begins at the following edge, giving back-to-back frames with zero idle bits.
- Frame length is exactly 10·`DIV` cycles, or 11·`DIV` with parity.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- Defined: one even-parity bit is inserted after bit 7. Its value is the XOR of the 8 latched data bits. Frame length is 11·`DIV`.
- Undefined: no PARITY state, plain 8N1, frame length 10·`DIV`.
- The receiver must be built with the same setting.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP).
  - Function computing `DIV` from the two real parameters.
  - Frame-length constants: data bits = 8, stop bits = 1.
- One natural sub-module, `uart_baud_counter`:
  - Counts to `DIV`-1, outputs a one-cycle `bit_end` pulse and restarts on a `clear` input.
  - Reusable by the receiver.

## Test plan
- Idle after reset: hold `rst` 3 cycles, then release -> `tx_stream`=1, `tx_busy`=0, `tx_done_tick`=0 for 20000 cycles with no `tx_start`.
- Single byte 0x55 at defaults, `tx_start` at edge k:
  - Line 0 for 868 cycles, then 1,0,1,0,1,0,1,0 at 868 cycles each, then 1 for 868 cycles.
  - `tx_done_tick` at edge k+8680, `tx_busy` high for exactly 8680 cycles.
- Back-to-back: 0xA3 then 0x0F, second `tx_start` held in the done-tick cycle -> second start bit at edge k+8681, total 17360 busy cycles with one busy-low cycle between frames.
- Busy rejection: `tx_start` with 0xFF at cycle k+2000 during a 0x00 frame -> line shows 0x00 data, exactly one `tx_done_tick`, no second frame.
- Reset mid-frame: `rst` at cycle k+3000 -> `tx_stream`=1 and `tx_busy`=0 next cycle, no `tx_done_tick`. A new `tx_start` afterwards sends a full frame.
- `UART_TX_PARITY_EN` defined, send 0x07 -> parity bit 1 at edge k+9·868, stop bit at k+10·868, `tx_done_tick` at k+9548.
